// File: rtl/pipe4_datapath_p.sv
// pipe4_datapath_p: single-clock 4-stage pipeline (operand read, ALU,
// register writeback, memory write) with valid/ready issue, global hold,
// bubbles and RAW forwarding from the ALU output and the S2 result.
module pipe4_datapath_p #(
    parameter int DW   = 16,
    parameter int NREG = 16,
    parameter int RAW  = 4,
    parameter int AW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    func,
    input  logic [RAW-1:0] rs1,
    input  logic [RAW-1:0] rs2,
    input  logic [RAW-1:0] rd,
    input  logic [AW-1:0] addr,
    input  logic          hold,
    output logic [DW-1:0] z,
    output logic          z_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          illegal_op
);

    typedef struct packed {
        logic [3:0]     func;
        logic [RAW-1:0] rd;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } s1_t;

    localparam int STAGES = 3;

    logic [DW-1:0] regbank [NREG];
    logic [DW-1:0] mem     [2**AW];

    // vld_pipe[1] = S1, [2] = S2 (z), [3] = S3 (memory write pending)
    logic [STAGES:1] vld_pipe;
    s1_t             s1;
    logic [RAW-1:0]  s2_rd;
    logic [AW-1:0]   s2_addr;
    logic [DW-1:0]   s3_res;
    logic [AW-1:0]   s3_addr;

    logic            issue;
    logic [DW-1:0]   alu_y;
    logic [DW-1:0]   opa, opb;

    assign in_ready = !hold;
    assign issue    = in_valid && !hold;

    // ALU on S1 contents; opcodes 12-15 produce 0
    always_comb begin
        alu_y = '0;
        case (s1.func)
            4'd0:    alu_y = s1.a + s1.b;
            4'd1:    alu_y = s1.a - s1.b;
            4'd2:    alu_y = s1.a * s1.b;
            4'd3:    alu_y = s1.a;
            4'd4:    alu_y = s1.b;
            4'd5:    alu_y = s1.a & s1.b;
            4'd6:    alu_y = s1.a | s1.b;
            4'd7:    alu_y = s1.a ^ s1.b;
            4'd8:    alu_y = ~s1.a;
            4'd9:    alu_y = ~s1.b;
            4'd10:   alu_y = s1.a >> 1;
            4'd11:   alu_y = s1.a << 1;
            default: alu_y = '0;
        endcase
    end

    // Operand read: newest in-flight producer wins; S3 already landed in regbank
    always_comb begin
        opa = regbank[rs1];
        opb = regbank[rs2];
        if (vld_pipe[1] && s1.rd == rs1)      opa = alu_y;
        else if (vld_pipe[2] && s2_rd == rs1) opa = z;
        if (vld_pipe[1] && s1.rd == rs2)      opb = alu_y;
        else if (vld_pipe[2] && s2_rd == rs2) opb = z;
    end

    // Stage registers and valid shift; everything freezes under hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1       <= '0;
            z        <= '0;
            s2_rd    <= '0;
            s2_addr  <= '0;
            s3_res   <= '0;
            s3_addr  <= '0;
        end else if (!hold) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], issue};
            if (issue) begin
                s1.func <= func;
                s1.rd   <= rd;
                s1.addr <= addr;
                s1.a    <= opa;
                s1.b    <= opb;
            end
            z       <= alu_y;
            s2_rd   <= s1.rd;
            s2_addr <= s1.addr;
            s3_res  <= z;
            s3_addr <= s2_addr;
        end
    end

    // Sticky illegal-opcode flag, set when an opcode 12-15 is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      illegal_op <= 1'b0;
        else if (issue && func[3] && func[2]) illegal_op <= 1'b1;
    end

    // Register writeback from S2; arrays are intentionally not reset
    always_ff @(posedge clk) begin
        if (!hold && vld_pipe[2]) regbank[s2_rd] <= z;
    end

    // Memory write from S3
    always_ff @(posedge clk) begin
        if (!hold && vld_pipe[3]) mem[s3_addr] <= s3_res;
    end

    assign z_valid   = vld_pipe[2];
    assign mem_we    = vld_pipe[3];
    assign mem_waddr = s3_addr;
    assign mem_wdata = s3_res;

endmodule

// File: tb/tb_pipe4_datapath_p.sv
// Directed bench for pipe4_datapath_p with hand-computed expectations.
module tb_pipe4_datapath_p;

    localparam int DW = 16, NREG = 16, RAW = 4, AW = 8;

    logic           clk, rst_n, in_valid, in_ready, hold;
    logic [3:0]     func;
    logic [RAW-1:0] rs1, rs2, rd;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  z, mem_wdata;
    logic           z_valid, mem_we, illegal_op;
    logic [AW-1:0]  mem_waddr;

    int checks = 0;
    int errors = 0;

    pipe4_datapath_p #(.DW(DW), .NREG(NREG), .RAW(RAW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .func(func), .rs1(rs1), .rs2(rs2), .rd(rd), .addr(addr), .hold(hold),
        .z(z), .z_valid(z_valid), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] f, input int a, input int b,
                         input int d, input int ad);
        in_valid = v;
        func     = f;
        rs1      = RAW'(a);
        rs2      = RAW'(b);
        rd       = RAW'(d);
        addr     = AW'(ad);
    endtask

    task automatic bubble();
        drive(1'b0, 4'd0, 0, 0, 0, 0);
    endtask

    logic [DW-1:0] exp_z [4];
    logic [DW-1:0] zs;
    logic          zvs;

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        bubble();
        for (int k = 0; k < NREG; k++) dut.regbank[k] = DW'(k);
        for (int k = 0; k < 2**AW; k++) dut.mem[k] = 16'hDEAD;
        #12;
        chk("rst_z", 32'(z), 0);
        chk("rst_zv", 32'(z_valid), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_ill", 32'(illegal_op), 0);
        chk("rst_rdy", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Back-to-back stream, third op needs S2 forward of r10
        exp_z[0] = 16'd8; exp_z[1] = 16'd24; exp_z[2] = 16'd3; exp_z[3] = 16'd14;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1'b1, 4'd0, 3, 5, 10, 155);
                1: drive(1'b1, 4'd2, 3, 8, 12, 156);
                2: drive(1'b1, 4'd1, 10, 5, 14, 157);
                3: drive(1'b1, 4'd11, 7, 0, 13, 158);
                default: bubble();
            endcase
            step();
            if (i > 0) begin
                chk($sformatf("seq_z%0d", i - 1), 32'(z), 32'(exp_z[i-1]));
                chk($sformatf("seq_zv%0d", i - 1), 32'(z_valid), 1);
            end
        end
        bubble();
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 4; i++) chk($sformatf("seq_mem%0d", 155 + i), 32'(dut.mem[155+i]), 32'(exp_z[i]));
        chk("seq_r10", 32'(dut.regbank[10]), 8);
        chk("seq_r14", 32'(dut.regbank[14]), 3);
        chk("seq_r12", 32'(dut.regbank[12]), 24);
        chk("seq_zv_idle", 32'(z_valid), 0);

        // Immediate dependency via live ALU forward
        drive(1'b1, 4'd0, 1, 2, 4, 40); step();
        drive(1'b1, 4'd1, 4, 1, 5, 41); step();
        chk("dep_z0", 32'(z), 3);
        bubble(); step();
        chk("dep_z1", 32'(z), 2);
        for (int i = 0; i < 4; i++) step();
        chk("dep_r5", 32'(dut.regbank[5]), 2);
        chk("dep_mem41", 32'(dut.mem[41]), 2);

        // Hold for three cycles right after issue
        drive(1'b1, 4'd0, 2, 3, 6, 10); step();
        hold = 1'b1;
        drive(1'b1, 4'd7, 1, 1, 6, 11);
        #1;
        chk("hold_rdy", 32'(in_ready), 0);
        zs = z; zvs = z_valid;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold_z%0d", i), 32'(z), 32'(zs));
            chk($sformatf("hold_zv%0d", i), 32'(z_valid), 32'(zvs));
            chk($sformatf("hold_we%0d", i), 32'(mem_we), 0);
        end
        hold = 1'b0;
        bubble();
        step();
        chk("hold_rel_z", 32'(z), 5);
        step();
        chk("hold_rel_we", 32'(mem_we), 1);
        chk("hold_rel_wa", 32'(mem_waddr), 10);
        chk("hold_rel_wd", 32'(mem_wdata), 5);
        chk("hold_mem_early", 32'(dut.mem[10]), 32'hDEAD);
        step();
        chk("hold_mem10", 32'(dut.mem[10]), 5);
        chk("hold_r6", 32'(dut.regbank[6]), 5);
        chk("hold_mem11", 32'(dut.mem[11]), 32'hDEAD);
        step(); step();

        // Multiply truncation
        dut.regbank[1] = 16'h0100;
        dut.regbank[2] = 16'h0101;
        drive(1'b1, 4'd2, 1, 2, 3, 50); step();
        bubble(); step();
        chk("mul_z", 32'(z), 32'h0100);
        for (int i = 0; i < 3; i++) step();
        chk("mul_r3", 32'(dut.regbank[3]), 32'h0100);

        // Illegal opcode, sticky across a later legal op
        dut.regbank[7] = 16'h7777;
        drive(1'b1, 4'd13, 1, 2, 7, 20); step();
        chk("ill_flag", 32'(illegal_op), 1);
        drive(1'b1, 4'd6, 1, 2, 8, 21); step();
        chk("ill_z", 32'(z), 0);
        bubble(); step();
        chk("ill_z_next", 32'(z), 32'h0101);
        chk("ill_sticky", 32'(illegal_op), 1);
        for (int i = 0; i < 4; i++) step();
        chk("ill_mem20", 32'(dut.mem[20]), 0);
        chk("ill_r7", 32'(dut.regbank[7]), 0);

        // Reset mid-pipe discards in-flight work
        dut.regbank[9] = 16'h0999;
        drive(1'b1, 4'd0, 1, 2, 9, 30); step();
        drive(1'b1, 4'd13, 1, 2, 11, 31); step();
        bubble();
        rst_n = 1'b0;
        #1;
        chk("mrst_z", 32'(z), 0);
        chk("mrst_zv", 32'(z_valid), 0);
        chk("mrst_ill", 32'(illegal_op), 0);
        chk("mrst_we", 32'(mem_we), 0);
        step(); step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("mrst_mem30", 32'(dut.mem[30]), 32'hDEAD);
        chk("mrst_mem31", 32'(dut.mem[31]), 32'hDEAD);
        chk("mrst_r9", 32'(dut.regbank[9]), 32'h0999);
        chk("mrst_keep", 32'(dut.mem[155]), 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
